// File: rtl/rom_crc_scanner.sv
// rom_crc_scanner: ROM self-test sequencer.
//
// Sweeps every ROM address from 0 to max, holds each address for SETTLE+1 clock
// edges, samples the returned byte on the last of those edges, and folds it into a
// CRC-8 signature (poly 0x07, MSB-first, init 0x00, no reflection, no final XOR).
// After sampling the last address it compares the signature with the golden value
// that was latched when the sweep started.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      level; begins a sweep when idle or done (ignored while running)
//   expected   golden signature, latched on the accepted start edge
//   rom_addr   registered ROM address
//   rom_data   ROM read data (combinational function of rom_addr)
//   busy       high while a sweep is running
//   done       sticky end-of-sweep flag, cleared by the next accepted start
//   pass       valid with done; 1 when the signature matched the latched golden value
//   signature  running CRC register; final value while done is high
module rom_crc_scanner #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        expected,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        signature
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0]        SettleCnt = 4'(SETTLE);
  localparam logic [ADDR_W-1:0] AddrMax   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] AddrOne   = {{(ADDR_W-1){1'b0}}, 1'b1};

  // One full byte of the bitwise CRC-8 recurrence, unrolled into a single cycle.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = {c[6:0], 1'b0} ^ (c[7] ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        sig_q, sig_d;
  logic [7:0]        exp_q, exp_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [7:0]        crc_next;

  assign crc_next = crc8_byte(sig_q, rom_data);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    exp_d   = exp_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          addr_d  = '0;
          cnt_d   = SettleCnt;
          sig_d   = 8'h00;
          exp_d   = expected;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          sig_d = crc_next;
          if (addr_q != AddrMax) begin
            addr_d = addr_q + AddrOne;
            cnt_d  = SettleCnt;
          end else begin
            // Last address sampled: address stays parked at max.
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = (crc_next == exp_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= 4'd0;
      sig_q   <= 8'h00;
      exp_q   <= 8'h00;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign rom_addr  = addr_q;
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule
